// File: rtl/display_capture_pkg.sv
// ============================================================================
// Package     : display_pkg
// Description : Shared constants, FSM state type and AN decode helpers for
//               the display_capture monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

  localparam int DIGITS   = 4;
  localparam int NIBBLE_W = 4;
  localparam int IDX_W    = $clog2(DIGITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } capture_state_t;

  typedef struct packed {
    logic             legal;
    logic [IDX_W-1:0] idx;
  } an_dec_t;

  // Active-low one-hot: exactly one cleared bit selects a digit.
  function automatic an_dec_t an_to_idx(input logic [DIGITS-1:0] an);
    an_dec_t d;
    d.legal = 1'b1;
    d.idx   = '0;
    case (an)
      4'b1110: d.idx = 2'd0;
      4'b1101: d.idx = 2'd1;
      4'b1011: d.idx = 2'd2;
      4'b0111: d.idx = 2'd3;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic an_is_legal(input logic [DIGITS-1:0] an);
    return ($countones(~an) == 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_capture_an_stability_filter.sv
// ============================================================================
// Module      : an_stability_filter
// Description : Registers AN, counts consecutive stable cycles (saturating)
//               and classifies AN as legal / blank / illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module an_stability_filter
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIGITS-1:0] i_an,
  output logic             o_changed,
  output logic             o_sample_point,
  output logic             o_legal,
  output logic             o_illegal_start,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [7:0] c_SETTLE    = 8'(SETTLE_CYCLES);
  localparam logic [7:0] c_SAMPLE_AT = 8'(SETTLE_CYCLES - 1);

  logic [DIGITS-1:0] r_an_q;
  logic [7:0]        r_stable_cnt;
  an_dec_t           w_dec;
  logic              w_blank;
  logic              w_illegal;
  logic              w_prev_illegal;

  assign w_dec          = an_to_idx(i_an);
  assign w_blank        = (i_an == '1);
  assign w_illegal      = !w_dec.legal && !w_blank;
  assign w_prev_illegal = !an_is_legal(r_an_q) && (r_an_q != '1);

  assign o_changed       = (i_an != r_an_q);
  assign o_sample_point  = !o_changed && (r_stable_cnt == c_SAMPLE_AT);
  assign o_legal         = w_dec.legal;
  assign o_idx           = w_dec.idx;
  // Only the first cycle of an illegal episode is reported.
  assign o_illegal_start = w_illegal && !w_prev_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an_q       <= '1;
      r_stable_cnt <= '0;
    end else begin
      r_an_q <= i_an;
      if (o_changed) begin
        r_stable_cnt <= '0;
      end else if (r_stable_cnt != c_SETTLE) begin
        r_stable_cnt <= r_stable_cnt + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_capture.sv
// ============================================================================
// Module      : display_capture
// Description : Rebuilds the parallel hex/point/LE word from a multiplexed
//               4-digit seven-segment bus; double-buffered frame outputs.
//               Optional macro DISPLAY_CAPTURE_ORDER_CHECK_EN enforces 0..3
//               digit order and drives order_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_capture
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int FRAME_TIMEOUT = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIGITS-1:0]            AN,
  input  logic [NIBBLE_W-1:0]          HEX,
  input  logic                         point,
  input  logic                         LE,
  output logic [DIGITS*NIBBLE_W-1:0]   hexs,
  output logic [DIGITS-1:0]            points,
  output logic [DIGITS-1:0]            LEs,
  output logic                         frame_valid,
  output logic                         an_err,
  output logic                         order_err
);

  localparam int  c_TO_W = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT + 1) : 1;
  localparam bit  c_TO_EN = (FRAME_TIMEOUT != 0);
  localparam logic [c_TO_W-1:0] c_TO     = c_TO_W'(FRAME_TIMEOUT);
  localparam logic [c_TO_W-1:0] c_TO_ONE = c_TO_W'(1);

  logic             w_changed;
  logic             w_sample_point;
  logic             w_legal;
  logic             w_illegal_start;
  logic [IDX_W-1:0] w_idx;

  an_stability_filter #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_filter (
    .clk             (clk),
    .rst             (rst),
    .i_an            (AN),
    .o_changed       (w_changed),
    .o_sample_point  (w_sample_point),
    .o_legal         (w_legal),
    .o_illegal_start (w_illegal_start),
    .o_idx           (w_idx)
  );

  capture_state_t r_state;
  capture_state_t w_state_nxt;
  logic           w_capture;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_legal) w_state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!w_legal) begin
          w_state_nxt = IDLE;
        end else if (w_sample_point) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_changed) w_state_nxt = w_legal ? SETTLE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  logic [DIGITS-1:0]                r_seen;
  logic [DIGITS-1:0]                w_seen_nxt;
  logic [DIGITS-1:0][NIBBLE_W-1:0]  r_shadow_hex;
  logic [DIGITS-1:0]                r_shadow_pt;
  logic [DIGITS-1:0]                r_shadow_le;
  logic [DIGITS-1:0][NIBBLE_W-1:0]  r_hexs;
  logic [DIGITS-1:0]                r_points;
  logic [DIGITS-1:0]                r_les;
  logic                             r_frame_valid;
  logic                             r_an_err;
  logic [c_TO_W-1:0]                r_to_cnt;
  logic                             w_commit;
  logic                             w_timeout;
  logic                             w_accept;
  logic                             w_order_err;

`ifdef DISPLAY_CAPTURE_ORDER_CHECK_EN
  logic [IDX_W-1:0] r_exp_idx;
  logic             w_in_order;
  logic             r_order_err;

  assign w_in_order  = (w_idx == r_exp_idx);
  // A misplaced digit 0 is taken as the start of a fresh frame.
  assign w_accept    = w_capture && (w_in_order || (w_idx == '0));
  assign w_order_err = w_capture && !w_in_order;
  assign order_err   = r_order_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp_idx   <= '0;
      r_order_err <= 1'b0;
    end else begin
      r_order_err <= w_order_err;
      if (w_capture) begin
        if (w_in_order)          r_exp_idx <= r_exp_idx + 2'd1;
        else if (w_idx == '0)    r_exp_idx <= 2'd1;
        else                     r_exp_idx <= '0;
      end
    end
  end
`else
  assign w_accept    = w_capture;
  assign w_order_err = 1'b0;
  assign order_err   = 1'b0;
`endif

  assign w_commit  = (r_seen == '1);
  assign w_timeout = c_TO_EN && !w_commit && (r_seen != '0) && !w_capture &&
                     (r_to_cnt == c_TO);

  always_comb begin
    w_seen_nxt = w_commit ? '0 : r_seen;
    if (w_order_err || w_timeout) w_seen_nxt = '0;
    if (w_accept) w_seen_nxt[w_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen        <= '0;
      r_shadow_hex  <= '0;
      r_shadow_pt   <= '0;
      r_shadow_le   <= '0;
      r_hexs        <= '0;
      r_points      <= '0;
      r_les         <= '0;
      r_frame_valid <= 1'b0;
      r_an_err      <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_seen        <= w_seen_nxt;
      r_frame_valid <= w_commit;
      r_an_err      <= w_illegal_start;
      // Outputs take the shadow as it stood before any same-cycle capture.
      if (w_commit) begin
        r_hexs   <= r_shadow_hex;
        r_points <= r_shadow_pt;
        r_les    <= r_shadow_le;
      end
      if (w_accept) begin
        r_shadow_hex[w_idx] <= HEX;
        r_shadow_pt[w_idx]  <= point;
        r_shadow_le[w_idx]  <= LE;
      end
      if (!c_TO_EN || w_capture || w_commit || w_timeout || (r_seen == '0)) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + c_TO_ONE;
      end
    end
  end

  assign hexs        = r_hexs;
  assign points      = r_points;
  assign LEs         = r_les;
  assign frame_valid = r_frame_valid;
  assign an_err      = r_an_err;

endmodule

`default_nettype wire

// File: tb/tb_display_capture.sv
// ============================================================================
// Module      : tb_display_capture
// Description : Self-checking bench for display_capture against a dwell-level
//               reference model (sample when AN has held SETTLE cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_capture;

  localparam int ST = 4;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  AN;
  logic [3:0]  HEX;
  logic        point;
  logic        LE;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  LEs;
  logic        frame_valid;
  logic        an_err;
  logic        order_err;

  int checks = 0;
  int errors = 0;

  display_capture #(
    .SETTLE_CYCLES (ST),
    .FRAME_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .AN          (AN),
    .HEX         (HEX),
    .point       (point),
    .LE          (LE),
    .hexs        (hexs),
    .points      (points),
    .LEs         (LEs),
    .frame_valid (frame_valid),
    .an_err      (an_err),
    .order_err   (order_err)
  );

  always #5 clk = ~clk;

  // Reference model state: frames built from dwell-level sampling events.
  logic [3:0]  m_prev_an;
  int          m_run;
  logic [3:0]  m_seen;
  int          m_to;
  int          m_exp;
  logic        m_pend;
  logic [3:0]  m_sh_hex [4];
  logic [3:0]  m_sh_pt, m_sh_le;
  logic [15:0] m_snap_hex, m_out_hex;
  logic [3:0]  m_snap_pt, m_snap_le, m_out_pt, m_out_le;
  int obs_fv = 0, obs_ae = 0, obs_oe = 0;
  int exp_fv = 0, exp_ae = 0, exp_oe = 0;
  int bad_cycles = 0;

  function automatic logic is_legal(input logic [3:0] a);
    int z = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) z++;
    return (z == 1);
  endfunction

  function automatic logic is_illegal(input logic [3:0] a);
    return !is_legal(a) && (a != 4'hF);
  endfunction

  function automatic int digit_of(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (!a[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_prev_an = 4'hF; m_run = 0; m_seen = '0; m_to = 0; m_exp = 0; m_pend = 1'b0;
    for (int i = 0; i < 4; i++) m_sh_hex[i] = '0;
    m_sh_pt = '0; m_sh_le = '0;
    m_out_hex = '0; m_out_pt = '0; m_out_le = '0;
  endtask

  task automatic model_store(input int idx, input logic [3:0] hx, input logic pt, input logic le);
    m_sh_hex[idx] = hx; m_sh_pt[idx] = pt; m_sh_le[idx] = le; m_seen[idx] = 1'b1;
  endtask

  task automatic step(input logic [3:0] an, input logic [3:0] hx, input logic pt, input logic le);
    logic e_fv, e_ae, e_oe, cap;
    int idx;
    AN = an; HEX = hx; point = pt; LE = le;
    @(posedge clk);
    @(negedge clk);
    e_fv = 1'b0; e_ae = 1'b0; e_oe = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (m_pend) begin
        e_fv = 1'b1; m_pend = 1'b0;
        m_out_hex = m_snap_hex; m_out_pt = m_snap_pt; m_out_le = m_snap_le;
      end
      e_ae = is_illegal(an) && !is_illegal(m_prev_an);
      if (an == m_prev_an) m_run++; else m_run = 0;
      m_prev_an = an;
      cap = is_legal(an) && (m_run == ST);
      idx = digit_of(an);
      if (cap) begin
        m_to = 0;
      end else if (m_seen != 0 && TO != 0) begin
        if (m_to == TO) begin m_seen = '0; m_to = 0; end
        else m_to++;
      end
      if (cap) begin
`ifdef DISPLAY_CAPTURE_ORDER_CHECK_EN
        if (idx == m_exp) begin
          model_store(idx, hx, pt, le); m_exp = (m_exp + 1) % 4;
        end else begin
          e_oe = 1'b1; m_seen = '0;
          if (idx == 0) begin model_store(idx, hx, pt, le); m_exp = 1; end
          else m_exp = 0;
        end
`else
        model_store(idx, hx, pt, le);
`endif
      end
      if (m_seen == 4'hF) begin
        m_pend = 1'b1; m_seen = '0; m_to = 0;
        m_snap_hex = {m_sh_hex[3], m_sh_hex[2], m_sh_hex[1], m_sh_hex[0]};
        m_snap_pt = m_sh_pt; m_snap_le = m_sh_le;
      end
    end
    if (frame_valid === 1'b1) obs_fv++;
    if (an_err === 1'b1) obs_ae++;
    if (order_err === 1'b1) obs_oe++;
    if (e_fv) exp_fv++;
    if (e_ae) exp_ae++;
    if (e_oe) exp_oe++;
    if (frame_valid !== e_fv || an_err !== e_ae || order_err !== e_oe ||
        hexs !== m_out_hex || points !== m_out_pt || LEs !== m_out_le) bad_cycles++;
  endtask

  task automatic dwell(input int d, input logic [3:0] hx, input logic pt, input logic le, input int len);
    logic [3:0] a;
    a = 4'hF; a[d] = 1'b0;
    for (int i = 0; i < len; i++) step(a, hx, pt, le);
  endtask

  task automatic blank(input int len);
    for (int i = 0; i < len; i++) step(4'hF, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    blank(3);
    checks += 4;
    if (hexs !== 16'h0) begin errors++; $display("FAIL reset_hexs: got %h expected 0000", hexs); end
    if (points !== 4'h0 || LEs !== 4'h0) begin errors++; $display("FAIL reset_pts_les: got %b/%b expected 0000/0000", points, LEs); end
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
    if (an_err !== 1'b0 || order_err !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b/%b expected 0/0", an_err, order_err); end
    rst = 1'b0;
    blank(2);
  endtask

  task automatic test_basic_scan();
    logic [3:0] le_bits;
    int fv0, bad0;
    le_bits = 4'($urandom);
    fv0 = obs_fv; bad0 = bad_cycles;
    for (int d = 0; d < 4; d++) dwell(d, 4'(d + 1), (d == 2), le_bits[d], 8);
    blank(3);
    checks += 5;
    if (obs_fv - fv0 !== 1) begin errors++; $display("FAIL basic_fv_count: got %0d expected 1", obs_fv - fv0); end
    if (hexs !== 16'h4321) begin errors++; $display("FAIL basic_hexs: got %h expected 4321", hexs); end
    if (points !== 4'b0100) begin errors++; $display("FAIL basic_points: got %b expected 0100", points); end
    if (LEs !== le_bits) begin errors++; $display("FAIL basic_les: got %b expected %b", LEs, le_bits); end
    if (bad_cycles !== bad0) begin errors++; $display("FAIL basic_model: got %0d bad cycles expected 0", bad_cycles - bad0); end
  endtask

  task automatic test_short_dwell();
    int fv0;
    fv0 = obs_fv;
    dwell(0, 4'hF, 1'b1, 1'b1, ST - 1);
    blank(1);
    dwell(0, 4'hA, 1'b0, 1'b0, 8);
    for (int d = 1; d < 4; d++) dwell(d, 4'(d + 1), 1'b0, 1'b0, 8);
    blank(3);
    checks += 3;
    if (obs_fv - fv0 !== 1) begin errors++; $display("FAIL short_fv_count: got %0d expected 1", obs_fv - fv0); end
    if (hexs !== 16'h432A) begin errors++; $display("FAIL short_hexs: got %h expected 432a", hexs); end
    if (points[0] !== 1'b0 || LEs[0] !== 1'b0) begin errors++; $display("FAIL short_digit0_bits: got %b/%b expected 0/0", points[0], LEs[0]); end
  endtask

  task automatic test_illegal_an();
    int fv0, ae0, bad0;
    fv0 = obs_fv; ae0 = obs_ae; bad0 = bad_cycles;
    dwell(0, 4'h9, 1'b0, 1'b1, 8);
    dwell(1, 4'h8, 1'b0, 1'b0, 8);
    for (int i = 0; i < 5; i++) step(4'b1100, 4'h1, 1'b1, 1'b1);
    dwell(2, 4'h7, 1'b1, 1'b0, 8);
    dwell(3, 4'h6, 1'b0, 1'b1, 8);
    blank(3);
    checks += 4;
    if (obs_ae - ae0 !== 1) begin errors++; $display("FAIL illegal_an_err_count: got %0d expected 1", obs_ae - ae0); end
    if (obs_fv - fv0 !== 1) begin errors++; $display("FAIL illegal_fv_count: got %0d expected 1", obs_fv - fv0); end
    if (hexs !== 16'h6789 || points !== 4'b0100 || LEs !== 4'b1001) begin
      errors++; $display("FAIL illegal_frame: got %h/%b/%b expected 6789/0100/1001", hexs, points, LEs);
    end
    if (bad_cycles !== bad0) begin errors++; $display("FAIL illegal_model: got %0d bad cycles expected 0", bad_cycles - bad0); end
  endtask

  task automatic test_reset_midframe();
    int fv0;
    dwell(0, 4'($urandom), 1'b1, 1'b1, 8);
    dwell(1, 4'($urandom), 1'b1, 1'b1, 8);
    rst = 1'b1;
    blank(2);
    rst = 1'b0;
    fv0 = obs_fv;
    for (int d = 0; d < 3; d++) dwell(d, 4'(d + 5), 1'b0, 1'b0, 8);
    checks += 4;
    if (obs_fv - fv0 !== 0) begin errors++; $display("FAIL midreset_early_fv: got %0d expected 0", obs_fv - fv0); end
    if (hexs !== 16'h0) begin errors++; $display("FAIL midreset_cleared: got %h expected 0000", hexs); end
    dwell(3, 4'h8, 1'b0, 1'b0, 8);
    blank(3);
    if (obs_fv - fv0 !== 1) begin errors++; $display("FAIL midreset_fv_count: got %0d expected 1", obs_fv - fv0); end
    if (hexs !== 16'h8765) begin errors++; $display("FAIL midreset_hexs: got %h expected 8765", hexs); end
  endtask

  task automatic test_timeout();
    int fv0, bad0;
    fv0 = obs_fv; bad0 = bad_cycles;
    dwell(0, 4'h1, 1'b0, 1'b0, 8);
    dwell(1, 4'h2, 1'b0, 1'b0, 8);
    blank(25);
    dwell(2, 4'h3, 1'b0, 1'b0, 8);
    dwell(3, 4'h4, 1'b0, 1'b0, 8);
    blank(25);
    checks += 4;
    if (obs_fv - fv0 !== 0) begin errors++; $display("FAIL timeout_no_commit: got %0d expected 0", obs_fv - fv0); end
    for (int d = 0; d < 4; d++) dwell(d, 4'(d + 11), 1'b1, 1'b0, 8);
    blank(3);
    if (obs_fv - fv0 !== 1) begin errors++; $display("FAIL timeout_then_commit: got %0d expected 1", obs_fv - fv0); end
    if (hexs !== 16'hEDCB || points !== 4'hF) begin errors++; $display("FAIL timeout_frame: got %h/%b expected edcb/1111", hexs, points); end
    if (bad_cycles !== bad0) begin errors++; $display("FAIL timeout_model: got %0d bad cycles expected 0", bad_cycles - bad0); end
  endtask

  task automatic test_order();
    int fv0, oe0, oe_d2;
    fv0 = obs_fv; oe0 = obs_oe;
    dwell(0, 4'h1, 1'b0, 1'b0, 8);
    dwell(2, 4'h3, 1'b0, 1'b0, 8);
    oe_d2 = obs_oe - oe0;
    dwell(1, 4'h2, 1'b0, 1'b0, 8);
    dwell(3, 4'h4, 1'b0, 1'b0, 8);
    blank(3);
    checks += 2;
`ifdef DISPLAY_CAPTURE_ORDER_CHECK_EN
    if (oe_d2 !== 1) begin errors++; $display("FAIL order_err_at_digit2: got %0d expected 1", oe_d2); end
    if (obs_fv - fv0 !== 0) begin errors++; $display("FAIL order_no_commit: got %0d expected 0", obs_fv - fv0); end
`else
    if (obs_oe - oe0 !== 0) begin errors++; $display("FAIL order_err_disabled: got %0d expected 0", obs_oe - oe0); end
    if (obs_fv - fv0 !== 1 || hexs !== 16'h4321) begin
      errors++; $display("FAIL order_any_accepted: got %0d/%h expected 1/4321", obs_fv - fv0, hexs);
    end
`endif
    fv0 = obs_fv;
    for (int d = 0; d < 4; d++) dwell(d, 4'(d + 5), 1'b0, 1'b1, 8);
    blank(3);
    checks += 1;
    if (obs_fv - fv0 !== 1 || hexs !== 16'h8765 || LEs !== 4'hF) begin
      errors++; $display("FAIL order_clean_scan: got %0d/%h/%b expected 1/8765/1111", obs_fv - fv0, hexs, LEs);
    end
  endtask

  task automatic test_back_to_back();
    int fv0;
    logic [15:0] last_hex;
    logic [3:0]  last_pt;
    fv0 = obs_fv;
    for (int s = 0; s < 5; s++) begin
      last_hex = 16'($urandom);
      last_pt  = 4'($urandom);
      for (int d = 0; d < 4; d++) dwell(d, last_hex[d*4 +: 4], last_pt[d], 1'b0, ST + 1);
    end
    blank(3);
    checks += 3;
    if (obs_fv - fv0 !== 5) begin errors++; $display("FAIL b2b_fv_count: got %0d expected 5", obs_fv - fv0); end
    if (hexs !== last_hex) begin errors++; $display("FAIL b2b_hexs: got %h expected %h", hexs, last_hex); end
    if (points !== last_pt) begin errors++; $display("FAIL b2b_points: got %b expected %b", points, last_pt); end
  endtask

  task automatic test_random();
    logic [3:0] bad_an [11];
    logic [3:0] a;
    int fv0, ae0, oe0, efv0, eae0, eoe0, bad0, r;
    bad_an = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hC};
    fv0 = obs_fv; ae0 = obs_ae; oe0 = obs_oe;
    efv0 = exp_fv; eae0 = exp_ae; eoe0 = exp_oe; bad0 = bad_cycles;
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 75) begin a = 4'hF; a[$urandom_range(0, 3)] = 1'b0; end
      else if (r < 88) a = 4'hF;
      else a = bad_an[$urandom_range(0, 10)];
      r = int'($urandom_range(1, 10));
      for (int i = 0; i < r; i++) step(a, 4'($urandom), 1'($urandom), 1'($urandom));
    end
    blank(3);
    checks += 4;
    if (bad_cycles !== bad0) begin errors++; $display("FAIL random_model: got %0d bad cycles expected 0", bad_cycles - bad0); end
    if (obs_fv - fv0 !== exp_fv - efv0) begin errors++; $display("FAIL random_fv_count: got %0d expected %0d", obs_fv - fv0, exp_fv - efv0); end
    if (obs_ae - ae0 !== exp_ae - eae0) begin errors++; $display("FAIL random_an_err_count: got %0d expected %0d", obs_ae - ae0, exp_ae - eae0); end
    if (obs_oe - oe0 !== exp_oe - eoe0) begin errors++; $display("FAIL random_order_err_count: got %0d expected %0d", obs_oe - oe0, exp_oe - eoe0); end
  endtask

  initial begin
    rst = 1'b1; AN = 4'hF; HEX = '0; point = 1'b0; LE = 1'b0;
    model_reset();
    test_reset();
    test_basic_scan();
    test_short_dwell();
    test_illegal_an();
    test_reset_midframe();
    test_timeout();
    test_order();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
